bip_control: RTL

- Instruction sequencer for the accumulator datapath.
- Fetches 16-bit instructions from a synchronous program memory, holds them in an instruction register and steps through a fixed 3-cycle FETCH/DECODE/EXECUTE sequence.
- Drives the datapath controls: sel_a, sel_b, wr_acc, op and operand.
- Drives the data-memory strobes rd_ram and wr_ram.
- Sits between program memory, the datapath and data memory; one instance per processor.

---
 rtl/bip_pkg.sv | 47 ++++
 rtl/bip_decoder.sv | 54 +++++
 rtl/bip_control.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared encodings for the bip instruction sequencer: opcodes, FSM states,
// accumulator/ALU select codes and the decoded control bundle.
package bip_pkg;

  localparam int unsigned OPC_BITS  = 5;
  localparam int unsigned OPND_BITS = 11;
  localparam int unsigned SEL_A_W   = 2;

  localparam logic [OPC_BITS-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_BITS-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_BITS-1:0] OPC_SUBI = 5'b00111;

  localparam logic [SEL_A_W-1:0] SEL_MEM = 2'b00;
  localparam logic [SEL_A_W-1:0] SEL_IMM = 2'b01;
  localparam logic [SEL_A_W-1:0] SEL_ALU = 2'b10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Per-opcode datapath controls; the *_en strobes are gated by state in the top.
  typedef struct packed {
    logic [SEL_A_W-1:0] sel_a;
    logic               sel_b;
    logic               op;
    logic               wr_acc_en;
    logic               wr_ram_en;
    logic               rd_ram_en;
  } ctrl_t;

  function automatic logic is_hlt(input logic [OPC_BITS-1:0] opc);
    return (opc == OPC_HLT);
  endfunction

endpackage

// File: rtl/bip_decoder.sv
// Pure opcode decoder: maps a 5-bit opcode onto the datapath control bundle.
// Unlisted opcodes decode to all-zero controls and therefore behave as NOP.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPC_BITS-1:0] opc,
  output ctrl_t               ctrl_c
);

  // Opcode to control-bundle lookup.
  always_comb begin
    ctrl_c = '0;
    case (opc)
      OPC_STO: ctrl_c.wr_ram_en = 1'b1;
      OPC_LD: begin
        ctrl_c.sel_a     = SEL_MEM;
        ctrl_c.wr_acc_en = 1'b1;
        ctrl_c.rd_ram_en = 1'b1;
      end
      OPC_LDI: begin
        ctrl_c.sel_a     = SEL_IMM;
        ctrl_c.wr_acc_en = 1'b1;
      end
      OPC_ADD: begin
        ctrl_c.sel_a     = SEL_ALU;
        ctrl_c.sel_b     = 1'b0;
        ctrl_c.op        = OP_ADD;
        ctrl_c.wr_acc_en = 1'b1;
        ctrl_c.rd_ram_en = 1'b1;
      end
      OPC_ADDI: begin
        ctrl_c.sel_a     = SEL_ALU;
        ctrl_c.sel_b     = 1'b1;
        ctrl_c.op        = OP_ADD;
        ctrl_c.wr_acc_en = 1'b1;
      end
      OPC_SUB: begin
        ctrl_c.sel_a     = SEL_ALU;
        ctrl_c.sel_b     = 1'b0;
        ctrl_c.op        = OP_SUB;
        ctrl_c.wr_acc_en = 1'b1;
        ctrl_c.rd_ram_en = 1'b1;
      end
      OPC_SUBI: begin
        ctrl_c.sel_a     = SEL_ALU;
        ctrl_c.sel_b     = 1'b1;
        ctrl_c.op        = OP_SUB;
        ctrl_c.wr_acc_en = 1'b1;
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// Instruction sequencer: FETCH/DECODE/EXECUTE over a synchronous program
// memory, driving accumulator datapath and data-memory strobes. Every output
// comes straight from a flop.
// Optional: define BIP_CYCLE_COUNT_EN to add a 32-bit busy-cycle counter.
//
// Fetch timing: the program memory returns data one cycle after the address.
// pc is advanced on the DECODE->EXECUTE edge so the next address is already
// presented during EXECUTE, and the word is valid during FETCH. ir and the
// decoded controls are captured leaving FETCH, so operand and rd_ram are
// stable throughout DECODE, one cycle ahead of the consuming wr_acc.
module bip_control
  import bip_pkg::*;
#(
  parameter int unsigned PC_W   = 11,
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned OPND_W = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OPC_W+OPND_W-1:0] pm_instr,
  output logic [PC_W-1:0]         pm_addr,
  output logic [OPND_W-1:0]       operand,
  output logic [1:0]              sel_a,
  output logic                    sel_b,
  output logic                    op,
  output logic                    wr_acc,
  output logic                    rd_ram,
  output logic                    wr_ram,
  output logic                    busy,
  output logic                    halted
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [31:0]             cycle_count
`endif
);

  localparam int unsigned INSTR_W = OPC_W + OPND_W;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                refill_q, refill_d;
  logic                wr_acc_q, wr_acc_d;
  logic                wr_ram_q, wr_ram_d;
  logic                rd_ram_q, rd_ram_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                start_ok_c;
  ctrl_t               pm_ctrl_c;
  logic [OPC_BITS-1:0] pm_opc_c;
  logic [OPC_BITS-1:0] ir_opc_c;

  assign pm_opc_c = OPC_BITS'(pm_instr[INSTR_W-1 -: OPC_W]);
  assign ir_opc_c = OPC_BITS'(ir_q[INSTR_W-1 -: OPC_W]);

  bip_decoder u_dec (
    .opc    (pm_opc_c),
    .ctrl_c (pm_ctrl_c)
  );

  // Next-state, pc/ir update and registered output decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ctrl_d     = ctrl_q;
    refill_d   = refill_q;
    start_ok_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          start_ok_c = 1'b1;
          state_d    = ST_FETCH;
          pc_d       = '0;
          // Leaving HALT the memory still shows the HLT word; wait one
          // extra FETCH cycle for word 0 to arrive.
          refill_d   = (state_q == ST_HALT);
        end
      end
      ST_FETCH: begin
        if (refill_q) begin
          refill_d = 1'b0;
        end else begin
          ir_d    = pm_instr;
          ctrl_d  = pm_ctrl_c;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
        if (!is_hlt(ir_opc_c)) pc_d = pc_q + PC_W'(1);
      end
      ST_EXECUTE: begin
        state_d = is_hlt(ir_opc_c) ? ST_HALT : ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
               (state_d == ST_EXECUTE);
    halted_d = (state_d == ST_HALT);
    rd_ram_d = (state_d == ST_DECODE)  && ctrl_d.rd_ram_en;
    wr_acc_d = (state_d == ST_EXECUTE) && ctrl_d.wr_acc_en;
    wr_ram_d = (state_d == ST_EXECUTE) && ctrl_d.wr_ram_en;
  end

  // State and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      ctrl_q   <= '0;
      refill_q <= 1'b0;
      wr_acc_q <= 1'b0;
      wr_ram_q <= 1'b0;
      rd_ram_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ctrl_q   <= ctrl_d;
      refill_q <= refill_d;
      wr_acc_q <= wr_acc_d;
      wr_ram_q <= wr_ram_d;
      rd_ram_q <= rd_ram_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign pm_addr = pc_q;
  assign operand = ir_q[OPND_W-1:0];
  assign sel_a   = ctrl_q.sel_a;
  assign sel_b   = ctrl_q.sel_b;
  assign op      = ctrl_q.op;
  assign wr_acc  = wr_acc_q;
  assign wr_ram  = wr_ram_q;
  assign rd_ram  = rd_ram_q;
  assign busy    = busy_q;
  assign halted  = halted_q;

`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Busy-cycle counter, restarted by every accepted start.
  always_comb begin
    cyc_d = cyc_q;
    if (start_ok_c) cyc_d = '0;
    else if (busy_q) cyc_d = cyc_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`endif

endmodule
